// File: rtl/matrix_operand_loader_pkg.sv
// Shared definitions for the operand loader: loader states, matrix size codes
// and the size-to-element-count decode also used by the adder's active count.
package matrix_operand_loader_pkg;

  localparam int ELEM_W   = 8;
  localparam int MAX_DIM  = 5;
  localparam int MAX_ELEM = MAX_DIM * MAX_DIM;
  localparam int BUS_W    = MAX_ELEM * ELEM_W;
  localparam int CNT_W    = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_A = 2'd1,
    ST_LOAD_B = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_2X2 = 2'b00;
  localparam logic [1:0] SIZE_3X3 = 2'b01;
  localparam logic [1:0] SIZE_4X4 = 2'b10;
  localparam logic [1:0] SIZE_5X5 = 2'b11;

  function automatic logic [CNT_W-1:0] size_to_n_elem(input logic [1:0] size);
    logic [CNT_W-1:0] n;
    case (size)
      SIZE_2X2: n = 5'd4;
      SIZE_3X3: n = 5'd9;
      SIZE_4X4: n = 5'd16;
      default:  n = 5'd25;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/matrix_operand_loader_elem_slot_writer.sv
// One packed operand register: whole-bus clear plus a single indexed element
// write per cycle. Element k lives at [k*ELEM_W +: ELEM_W].
module matrix_operand_loader_elem_slot_writer
  import matrix_operand_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_we,
  input  logic [CNT_W-1:0]  i_idx,
  input  logic [ELEM_W-1:0] i_data,
  output logic [BUS_W-1:0]  o_bus
);

  logic [BUS_W-1:0] r_bus;

  // Clear wins over a write; slots at or beyond the active count are never addressed.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_bus <= '0;
    end else if (i_we) begin
      for (int k = 0; k < MAX_ELEM; k++) begin
        if (i_idx == CNT_W'(k)) begin
          r_bus[k*ELEM_W +: ELEM_W] <= i_data;
        end
      end
    end
  end

  assign o_bus = r_bus;

endmodule

// File: rtl/matrix_operand_loader.sv
// Streams matrix elements (A then B, row-major) into two packed operand buses
// and holds them with 'loaded' until the downstream consumer acks.
module matrix_operand_loader
  import matrix_operand_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        matrix_size,
  input  logic [ELEM_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              ack,
  output logic [BUS_W-1:0]  matrix_A,
  output logic [BUS_W-1:0]  matrix_B,
  output logic [1:0]        size_out,
  output logic              busy,
  output logic              loaded,
  output state_t            dbg_state
);

  // Handshake: an element moves when data_valid && data_ready on a rising
  // edge; data_ready is a pure decode of the registered state (LOAD_A/LOAD_B),
  // so it never depends combinationally on data_valid.

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_count;
  logic [1:0]       r_size;

  logic             w_start_take;
  logic             w_transfer;
  logic             w_last;
  logic [CNT_W-1:0] w_n_elem;

  assign w_n_elem     = size_to_n_elem(r_size);
  assign w_start_take = (r_state == ST_IDLE) && start;
  assign data_ready   = (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B);
  assign w_transfer   = data_valid && data_ready;
  assign w_last       = (r_count == (w_n_elem - 5'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next_state = ST_LOAD_A;
      ST_LOAD_A: if (w_transfer && w_last) w_next_state = ST_LOAD_B;
      ST_LOAD_B: if (w_transfer && w_last) w_next_state = ST_DONE;
      ST_DONE:   if (ack) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // The counter wraps to 0 on the last A element so B starts at slot 0 with no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_size  <= SIZE_2X2;
    end else if (w_start_take) begin
      r_count <= '0;
      r_size  <= matrix_size;
    end else if (w_transfer) begin
      r_count <= w_last ? '0 : r_count + 5'd1;
    end
  end

  matrix_operand_loader_elem_slot_writer u_slot_a (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_start_take),
    .i_we    (w_transfer && (r_state == ST_LOAD_A)),
    .i_idx   (r_count),
    .i_data  (data_in),
    .o_bus   (matrix_A)
  );

  matrix_operand_loader_elem_slot_writer u_slot_b (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_start_take),
    .i_we    (w_transfer && (r_state == ST_LOAD_B)),
    .i_idx   (r_count),
    .i_data  (data_in),
    .o_bus   (matrix_B)
  );

  assign size_out  = r_size;
  assign busy      = data_ready;
  assign loaded    = (r_state == ST_DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed-plus-random bench for the operand loader; expected buses are built
// from the streamed element lists, not from the loader's internals.
module tb_matrix_operand_loader;
  import matrix_operand_loader_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   matrix_size;
  logic [7:0]   data_in;
  logic         data_valid;
  logic         data_ready;
  logic         ack;
  logic [199:0] matrix_A;
  logic [199:0] matrix_B;
  logic [1:0]   size_out;
  logic         busy;
  logic         loaded;
  state_t       dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] va [25];
  logic [7:0] vb [25];
  logic [199:0] hold_a, hold_b;
  int cyc;

  matrix_operand_loader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .matrix_size (matrix_size),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .ack         (ack),
    .matrix_A    (matrix_A),
    .matrix_B    (matrix_B),
    .size_out    (size_out),
    .busy        (busy),
    .loaded      (loaded),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int n_of(input logic [1:0] sz);
    return (int'(sz) + 2) * (int'(sz) + 2);
  endfunction

  // Reference packing: first n elements of the list, row-major, rest zero.
  function automatic logic [199:0] pack(input int n, input bit is_b);
    logic [199:0] bus;
    bus = '0;
    for (int k = 0; k < n; k++) bus[k*8 +: 8] = is_b ? vb[k] : va[k];
    return bus;
  endfunction

  // Start a load and stream all 2n elements with random stalls; optionally
  // pulse start (with a different size) alongside element index pulse_at.
  task automatic run_load(input logic [1:0] sz, input int max_gap, input int pulse_at,
                          output int cycles);
    int n;
    int gaps;
    n = n_of(sz);
    start = 1'b1;
    matrix_size = sz;
    tick();
    cycles = 1;
    start = 1'b0;
    for (int i = 0; i < 2 * n; i++) begin
      gaps = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      repeat (gaps) begin
        data_valid = 1'b0;
        data_in = 8'($urandom);
        check("ready_in_load", {199'b0, data_ready}, 200'd1);
        tick();
        cycles++;
      end
      check("busy_in_load", {199'b0, busy}, 200'd1);
      check("not_loaded_in_load", {199'b0, loaded}, 200'd0);
      data_valid = 1'b1;
      data_in = (i < n) ? va[i] : vb[i - n];
      if (i == pulse_at) begin
        start = 1'b1;
        matrix_size = SIZE_4X4;
      end
      tick();
      cycles++;
      start = 1'b0;
    end
    data_valid = 1'b0;
  endtask

  task automatic check_done(input logic [1:0] sz, input string tag);
    int n;
    n = n_of(sz);
    check({tag, "_A"}, matrix_A, pack(n, 1'b0));
    check({tag, "_B"}, matrix_B, pack(n, 1'b1));
    check({tag, "_size"}, {198'b0, size_out}, {198'b0, sz});
    check({tag, "_loaded"}, {199'b0, loaded}, 200'd1);
    check({tag, "_busy"}, {199'b0, busy}, 200'd0);
    check({tag, "_ready"}, {199'b0, data_ready}, 200'd0);
    check({tag, "_state"}, {198'b0, dbg_state}, {198'b0, ST_DONE});
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    matrix_size = 2'b00;
    data_in = 8'h00;
    data_valid = 1'b0;
    ack = 1'b0;
    tick();
    tick();
    check("rst_A", matrix_A, 200'd0);
    check("rst_B", matrix_B, 200'd0);
    check("rst_flags", {195'b0, size_out, data_ready, busy, loaded}, 200'd0);
    reset = 1'b0;
    tick();

    // 2x2 load with valid every cycle
    for (int k = 0; k < 4; k++) begin
      va[k] = 8'(k + 1);
      vb[k] = 8'((k + 1) * 10);
    end
    run_load(SIZE_2X2, 0, -1, cyc);
    check("t1_latency", 200'(cyc), 200'd9);
    check_done(SIZE_2X2, "t1");
    check("t1_A_low", {168'b0, matrix_A[31:0]}, {168'b0, 32'h04030201});
    check("t1_B_low", {168'b0, matrix_B[31:0]}, {168'b0, 32'h281E140A});
    check("t1_A_high", {32'b0, matrix_A[199:32]}, 200'd0);

    // start together with ack in DONE: only the ack acts
    ack = 1'b1;
    start = 1'b1;
    matrix_size = SIZE_5X5;
    tick();
    ack = 1'b0;
    start = 1'b0;
    check("t1_ack_loaded", {199'b0, loaded}, 200'd0);
    check("t1_ack_size", {198'b0, size_out}, 200'd0);
    check("t1_retain_A", matrix_A, pack(4, 1'b0));
    tick();
    check("t1_no_start_busy", {199'b0, busy}, 200'd0);
    check("t1_idle_state", {198'b0, dbg_state}, {198'b0, ST_IDLE});

    // 5x5 with random stalls
    for (int k = 0; k < 25; k++) begin
      va[k] = 8'(k);
      vb[k] = 8'(k + 25);
    end
    run_load(SIZE_5X5, 3, -1, cyc);
    check_done(SIZE_5X5, "t2");
    check("t2_A_last", {192'b0, matrix_A[199:192]}, 200'd24);
    check("t2_B_last", {192'b0, matrix_B[199:192]}, 200'd49);

    // DONE holds while data_valid toggles and ack stays low
    hold_a = pack(25, 1'b0);
    hold_b = pack(25, 1'b1);
    for (int i = 0; i < 10; i++) begin
      data_valid = i[0];
      data_in = 8'($urandom);
      tick();
      check("t5_hold_A", matrix_A, hold_a);
      check("t5_hold_B", matrix_B, hold_b);
      check("t5_hold_flags", {197'b0, loaded, data_ready, busy}, {197'b0, 3'b100});
    end
    data_valid = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t5_ack_drop", {199'b0, loaded}, 200'd0);

    // Back-to-back: start right after the ack, 2x2 after 5x5
    for (int k = 0; k < 25; k++) begin
      va[k] = 8'($urandom);
      vb[k] = 8'($urandom);
    end
    run_load(SIZE_2X2, 2, -1, cyc);
    check_done(SIZE_2X2, "t6");
    check("t6_A_stale", {32'b0, matrix_A[199:32]}, 200'd0);
    check("t6_B_stale", {32'b0, matrix_B[199:32]}, 200'd0);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // Reset after 5 of 9 A elements
    start = 1'b1;
    matrix_size = SIZE_3X3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_valid = 1'b1;
      data_in = 8'($urandom_range(1, 255));
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    data_valid = 1'b0;
    check("t3_rst_A", matrix_A, 200'd0);
    check("t3_rst_B", matrix_B, 200'd0);
    check("t3_rst_flags", {195'b0, size_out, data_ready, busy, loaded}, 200'd0);
    check("t3_rst_state", {198'b0, dbg_state}, {198'b0, ST_IDLE});

    // Clean reload; start pulse during LOAD_B must be ignored
    for (int k = 0; k < 25; k++) begin
      va[k] = 8'($urandom);
      vb[k] = 8'($urandom);
    end
    run_load(SIZE_3X3, 2, 11, cyc);
    check_done(SIZE_3X3, "t3t4");
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t4_final_idle", {198'b0, dbg_state}, {198'b0, ST_IDLE});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
